// File: rtl/wb_gpio_core.sv
// wb_gpio_core: GPIO register block behind the Wishbone subordinate interface.
// It holds the output, direction and edge-enable registers, synchronises the pin
// inputs, and emits one-cycle per-pin edge pulses toward the sticky IRQ register.
// Optional input debounce is compiled in when GPIO_DEBOUNCE_EN is defined.
// Register port handshake: every read or write strobe is acknowledged in the same
// cycle (o_ip_ack = read_en | write_en) and the core never stalls.
module wb_gpio_core #(
    parameter int WB_DATA_WIDTH             = 32,
    parameter int WB_REGISTER_ADDRESS_WIDTH = 16,
    parameter int GPIO_WIDTH                = 32,
    parameter int SYNC_STAGES               = 2,
    parameter int DEBOUNCE_CYCLES           = 16
) (
    input  logic                                 i_wb_clk,
    input  logic                                 i_wb_rst,
    input  logic [WB_REGISTER_ADDRESS_WIDTH-1:0] i_ip_address,
    output logic [WB_DATA_WIDTH-1:0]             o_ip_rdata,
    input  logic [WB_DATA_WIDTH-1:0]             i_ip_wdata,
    input  logic                                 i_ip_read_en,
    input  logic                                 i_ip_write_en,
    output logic                                 o_ip_ack,
    output logic                                 o_ip_stall,
    input  logic [WB_DATA_WIDTH-1:0]             i_ip_control,
    output logic [WB_DATA_WIDTH-1:0]             o_ip_status,
    output logic [WB_DATA_WIDTH-1:0]             o_ip_irq,
    input  logic [GPIO_WIDTH-1:0]                i_gpio,
    output logic [GPIO_WIDTH-1:0]                o_gpio,
    output logic [GPIO_WIDTH-1:0]                o_gpio_oe
);

    localparam int AW = WB_REGISTER_ADDRESS_WIDTH;
    localparam logic [AW-1:0] ADDR_DATA_OUT = AW'('h20);
    localparam logic [AW-1:0] ADDR_DATA_IN  = AW'('h24);
    localparam logic [AW-1:0] ADDR_DIR      = AW'('h28);
    localparam logic [AW-1:0] ADDR_RISE_EN  = AW'('h2C);
    localparam logic [AW-1:0] ADDR_FALL_EN  = AW'('h30);
    localparam logic [AW-1:0] ADDR_SET      = AW'('h34);
    localparam logic [AW-1:0] ADDR_CLR      = AW'('h38);

`ifdef GPIO_DEBOUNCE_EN
    localparam bit DB_PRESENT = 1'b1;
`else
    localparam bit DB_PRESENT = 1'b0;
`endif
    localparam int DB_EXTRA   = DB_PRESENT ? DEBOUNCE_CYCLES : 0;
    // Edge detection stays muted until the reset-time contents have flushed
    // through the input path, so pins already high at reset cannot look like edges.
    localparam int ARM_CYCLES = SYNC_STAGES + 1 + DB_EXTRA;
    localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

    logic [GPIO_WIDTH-1:0]                  data_out;
    logic [GPIO_WIDTH-1:0]                  dir;
    logic [GPIO_WIDTH-1:0]                  rise_en;
    logic [GPIO_WIDTH-1:0]                  fall_en;
    logic [SYNC_STAGES-1:0][GPIO_WIDTH-1:0] sync_q;
    logic [GPIO_WIDTH-1:0]                  synced;
    logic [GPIO_WIDTH-1:0]                  data_in;
    logic [GPIO_WIDTH-1:0]                  prev_q;
    logic [GPIO_WIDTH-1:0]                  irq_q;
    logic [GPIO_WIDTH-1:0]                  edges;
    logic [GPIO_WIDTH-1:0]                  rd_bits;
    logic [ARM_W-1:0]                       arm_cnt;
    logic                                   armed;
    logic                                   core_en;
    logic                                   unused_control_bits;

    assign core_en             = i_ip_control[0];
    assign unused_control_bits = ^i_ip_control[WB_DATA_WIDTH-1:1];
    assign o_ip_ack            = i_ip_read_en | i_ip_write_en;
    assign o_ip_stall          = 1'b0;
    assign o_gpio              = data_out;
    assign o_gpio_oe           = dir & {GPIO_WIDTH{core_en}};
    assign synced              = sync_q[SYNC_STAGES-1];
    assign armed               = (arm_cnt == ARM_W'(ARM_CYCLES));
    assign edges               = (data_in & ~prev_q & rise_en) | (~data_in & prev_q & fall_en);

    // Register writes; SET/CLR modify DATA_OUT and have no storage of their own.
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            data_out <= '0;
            dir      <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
        end else if (i_ip_write_en) begin
            case (i_ip_address)
                ADDR_DATA_OUT: data_out <= i_ip_wdata[GPIO_WIDTH-1:0];
                ADDR_DIR:      dir      <= i_ip_wdata[GPIO_WIDTH-1:0];
                ADDR_RISE_EN:  rise_en  <= i_ip_wdata[GPIO_WIDTH-1:0];
                ADDR_FALL_EN:  fall_en  <= i_ip_wdata[GPIO_WIDTH-1:0];
                ADDR_SET:      data_out <= data_out | i_ip_wdata[GPIO_WIDTH-1:0];
                ADDR_CLR:      data_out <= data_out & ~i_ip_wdata[GPIO_WIDTH-1:0];
                default:       ;
            endcase
        end
    end

    // Combinational read decode; write-only and unmapped offsets read as zero.
    always_comb begin
        rd_bits = '0;
        case (i_ip_address)
            ADDR_DATA_OUT: rd_bits = data_out;
            ADDR_DATA_IN:  rd_bits = data_in;
            ADDR_DIR:      rd_bits = dir;
            ADDR_RISE_EN:  rd_bits = rise_en;
            ADDR_FALL_EN:  rd_bits = fall_en;
            default:       rd_bits = '0;
        endcase
        o_ip_rdata = '0;
        o_ip_rdata[GPIO_WIDTH-1:0] = rd_bits;
    end

    // Multi-flop synchroniser for the asynchronous pin inputs.
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= i_gpio;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [GPIO_WIDTH-1:0][DB_W-1:0] db_cnt;
    logic [GPIO_WIDTH-1:0]           cond_q;

    // Per-pin debounce: accept a new level only after it has persisted long enough.
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            db_cnt <= '0;
            cond_q <= '0;
        end else begin
            for (int p = 0; p < GPIO_WIDTH; p++) begin
                if (synced[p] != cond_q[p]) begin
                    if (db_cnt[p] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        cond_q[p] <= synced[p];
                        db_cnt[p] <= '0;
                    end else begin
                        db_cnt[p] <= db_cnt[p] + DB_W'(1);
                    end
                end else begin
                    db_cnt[p] <= '0;
                end
            end
        end
    end

    assign data_in = cond_q;
`else
    assign data_in = synced;
`endif

    // Arm counter saturates once the input path holds real pin data.
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            arm_cnt <= '0;
        end else if (!armed) begin
            arm_cnt <= arm_cnt + ARM_W'(1);
        end
    end

    // Edge history always tracks; pulses are dropped while disabled or not yet armed.
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            prev_q <= '0;
            irq_q  <= '0;
        end else begin
            prev_q <= data_in;
            irq_q  <= edges & {GPIO_WIDTH{core_en & armed}};
        end
    end

    // Widen the pin-level pulses and status flags onto the data-width buses.
    always_comb begin
        o_ip_irq = '0;
        o_ip_irq[GPIO_WIDTH-1:0] = irq_q;
        o_ip_status    = '0;
        o_ip_status[0] = core_en;
        o_ip_status[1] = armed;
        o_ip_status[2] = DB_PRESENT;
    end

endmodule

// File: tb/tb_wb_gpio_core.sv
// tb_wb_gpio_core: directed register and pin-edge vectors for wb_gpio_core.
// Register reads and pin edges push expected values into queues; a monitor on
// the falling clock edge pops and compares whenever the DUT acks a read or
// raises an IRQ pulse.
module tb_wb_gpio_core;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int GW = 32;
    localparam int SS = 2;
    localparam int DB = 16;
`ifdef GPIO_DEBOUNCE_EN
    localparam int          LAT   = SS + 1 + DB;
    localparam logic [31:0] ST_DB = 32'h4;
`else
    localparam int          LAT   = SS + 1;
    localparam logic [31:0] ST_DB = 32'h0;
`endif
    localparam int SETTLE = LAT + 4;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } irq_exp_t;

    logic          clk;
    logic          rst;
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
    logic [DW-1:0] wdata;
    logic          rd_en;
    logic          wr_en;
    logic          ack;
    logic          stall;
    logic [DW-1:0] control;
    logic [DW-1:0] status;
    logic [DW-1:0] irq;
    logic [GW-1:0] gpio_in;
    logic [GW-1:0] gpio_out;
    logic [GW-1:0] gpio_oe;

    logic [31:0] exp_q[$];
    string       name_q[$];
    irq_exp_t    irq_q[$];
    int          cyc;
    int          errors;
    int          checks;

    wb_gpio_core #(
        .WB_DATA_WIDTH(DW),
        .WB_REGISTER_ADDRESS_WIDTH(AW),
        .GPIO_WIDTH(GW),
        .SYNC_STAGES(SS),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .i_wb_clk(clk),
        .i_wb_rst(rst),
        .i_ip_address(addr),
        .o_ip_rdata(rdata),
        .i_ip_wdata(wdata),
        .i_ip_read_en(rd_en),
        .i_ip_write_en(wr_en),
        .o_ip_ack(ack),
        .o_ip_stall(stall),
        .i_ip_control(control),
        .o_ip_status(status),
        .o_ip_irq(irq),
        .i_gpio(gpio_in),
        .o_gpio(gpio_out),
        .o_gpio_oe(gpio_oe)
    );

    // clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: compares acked reads and every IRQ pulse against the queues
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_en || wr_en) check("ack", {31'b0, ack}, 32'h1);
            if (rd_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rdata_unexpected: got %h expected no read", rdata);
                end else begin
                    check(name_q.pop_front(), rdata, exp_q.pop_front());
                end
            end
            if (irq != '0) begin
                if (irq_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL irq_unexpected: got %h expected none (cycle %0d)", irq, cyc);
                end else begin
                    irq_exp_t e;
                    e = irq_q.pop_front();
                    check("irq_value", irq, e.val);
                    check("irq_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // driver tasks
    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [31:0] exp, input string name);
        @(posedge clk);
        #1;
        addr  = a;
        rd_en = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic pins(input logic [31:0] v, input logic [31:0] exp_irq);
        @(posedge clk);
        #1;
        gpio_in = v;
        if (exp_irq != '0) irq_q.push_back('{exp_irq, cyc + LAT});
    endtask

    task automatic set_en(input logic en);
        @(posedge clk);
        #1;
        control = {31'b0, en};
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst     = 1'b1;
        addr    = '0;
        wdata   = '0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        control = '0;
        gpio_in = 32'hFFFF_FFFF;

        // reset state with all pins high
        repeat (3) @(negedge clk);
        check("rst_gpio", gpio_out, 32'h0);
        check("rst_oe", gpio_oe, 32'h0);
        check("rst_irq", irq, 32'h0);
        check("rst_ack", {31'b0, ack}, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'h0);
        rst     = 1'b0;
        control = 32'h1;

        // pins high through arm window: no IRQ, DATA_IN reflects pins
        idle(SETTLE + 5);
        rd(16'h24, 32'hFFFF_FFFF, "data_in_after_arm");
        @(negedge clk);
        check("status", status, 32'h3 | ST_DB);

        // output and direction registers
        wr(16'h28, 32'hFF);
        wr(16'h20, 32'hA5);
        @(negedge clk);
        check("oe_enabled", gpio_oe, 32'hFF);
        check("gpio_out", gpio_out, 32'hA5);
        set_en(1'b0);
        @(negedge clk);
        check("oe_disabled", gpio_oe, 32'h0);
        check("gpio_out_disabled", gpio_out, 32'hA5);
        check("status_disabled", status, 32'h2 | ST_DB);
        set_en(1'b1);

        // SET/CLR
        wr(16'h20, 32'h0F);
        wr(16'h34, 32'h30);
        wr(16'h38, 32'h01);
        rd(16'h20, 32'h3E, "data_out_set_clr");
        rd(16'h34, 32'h0, "set_reads_zero");
        rd(16'h38, 32'h0, "clr_reads_zero");
        rd(16'h28, 32'hFF, "dir_readback");

        // rising edge on pin0, no falling IRQ with FALL_EN=0
        pins(32'h0, 32'h0);
        idle(SETTLE);
        wr(16'h2C, 32'h1);
        wr(16'h30, 32'h0);
        pins(32'h1, 32'h1);
        idle(SETTLE);
        pins(32'h0, 32'h0);
        idle(SETTLE);

        // falling edge on pin1 only
        wr(16'h30, 32'h2);
        pins(32'h2, 32'h0);
        idle(SETTLE);
        pins(32'h0, 32'h2);
        idle(SETTLE);

        // edges while disabled are dropped and not replayed
        set_en(1'b0);
        pins(32'h1, 32'h0);
        idle(SETTLE);
        set_en(1'b1);
        idle(SETTLE);
        rd(16'h24, 32'h1, "data_in_pin0");

        // unmapped offsets
        rd(16'h3C, 32'h0, "unmapped_read");
        wr(16'h40, 32'hFFFF_FFFF);
        rd(16'h20, 32'h3E, "data_out_after_unmapped");
        rd(16'h28, 32'hFF, "dir_after_unmapped");
        rd(16'h2C, 32'h1, "rise_en_after_unmapped");
        rd(16'h30, 32'h2, "fall_en_after_unmapped");

        // pin3 rising edge (glitch rejection when debounce is built in)
        wr(16'h2C, 32'h8);
`ifdef GPIO_DEBOUNCE_EN
        pins(32'h9, 32'h0);
        idle(9);
        pins(32'h1, 32'h0);
        idle(SETTLE);
        rd(16'h24, 32'h1, "data_in_glitch_rejected");
        pins(32'h9, 32'h8);
        idle(19);
        rd(16'h24, 32'h9, "data_in_debounced");
`else
        pins(32'h9, 32'h8);
        idle(SETTLE);
        rd(16'h24, 32'h9, "data_in_pin3");
`endif
        pins(32'h1, 32'h0);
        idle(SETTLE);

        // final report
        if (irq_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL irq_missing: got %0d pulses outstanding expected 0", irq_q.size());
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL read_missing: got %0d reads outstanding expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
